// File: rtl/bus_xbar_mn.sv
// NrHosts x NrDevices crossbar for the req/gnt/rvalid bus.
// Address decode per host, round-robin arbitration per device with owner
// locking until grant, one outstanding transaction per host, decode-error
// responses, and a sticky flag for responses that nobody is waiting for.
module bus_xbar_mn #(
  parameter int NrHosts   = 2,
  parameter int NrDevices = 4,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NrDevices*AW-1:0] cfg_addr_base_i,
  input  logic [NrDevices*AW-1:0] cfg_addr_mask_i,
  input  logic [NrHosts-1:0]      host_req_i,
  input  logic [NrHosts-1:0]      host_we_i,
  input  logic [NrHosts*DW/8-1:0] host_be_i,
  input  logic [NrHosts*AW-1:0]   host_addr_i,
  input  logic [NrHosts*DW-1:0]   host_wdata_i,
  output logic [NrHosts-1:0]      host_gnt_o,
  output logic [NrHosts-1:0]      host_rvalid_o,
  output logic [NrHosts*DW-1:0]   host_rdata_o,
  output logic [NrHosts-1:0]      host_err_o,
  output logic [NrDevices-1:0]    dev_req_o,
  output logic [NrDevices-1:0]    dev_we_o,
  output logic [NrDevices*DW/8-1:0] dev_be_o,
  output logic [NrDevices*AW-1:0] dev_addr_o,
  output logic [NrDevices*DW-1:0] dev_wdata_o,
  input  logic [NrDevices-1:0]    dev_gnt_i,
  input  logic [NrDevices-1:0]    dev_rvalid_i,
  input  logic [NrDevices*DW-1:0] dev_rdata_i,
  input  logic [NrDevices-1:0]    dev_err_i,
  output logic                    protocol_err_o
);

  localparam int          BW   = DW / 8;
  localparam int          HW   = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int          DevW = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int unsigned NH   = NrHosts;

  typedef enum logic [1:0] {IDLE, REQ, BUSY} dev_state_e;

  dev_state_e         state_q   [NrDevices];
  dev_state_e         state_d   [NrDevices];
  logic [HW-1:0]      owner_q   [NrDevices];
  logic [HW-1:0]      rr_q      [NrDevices];
  logic [HW-1:0]      arb_owner [NrDevices];
  logic [HW-1:0]      cur_owner [NrDevices];
  logic [NrDevices-1:0] arb_valid, dev_act, dev_hs;
  logic [NrHosts-1:0] pending_q, derr_q, dec_hit, derr_gnt;
  logic [DevW-1:0]    dec_dev   [NrHosts];
  logic               proto_err_q;

  assign protocol_err_o = proto_err_q;

  // Address decode per host; later (higher) device indices override earlier hits.
  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) begin
      dec_hit[h] = 1'b0;
      dec_dev[h] = '0;
      for (int unsigned d = 0; d < NrDevices; d++) begin
        if ((host_addr_i[h*AW +: AW] & cfg_addr_mask_i[d*AW +: AW]) == cfg_addr_base_i[d*AW +: AW]) begin
          dec_hit[h] = 1'b1;
          dec_dev[h] = DevW'(d);
        end
      end
      derr_gnt[h] = !rst_i && host_req_i[h] && !pending_q[h] && !dec_hit[h];
    end
  end

  // Per-device round-robin pick, owner selection and next-state logic.
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      arb_valid[d] = 1'b0;
      arb_owner[d] = '0;
      for (int unsigned i = 0; i < NrHosts; i++) begin
        idx = (32'(rr_q[d]) + i) % NH;
        if (!arb_valid[d] && host_req_i[idx] && !pending_q[idx] && dec_hit[idx] &&
            dec_dev[idx] == DevW'(d)) begin
          arb_valid[d] = 1'b1;
          arb_owner[d] = HW'(idx);
        end
      end
      cur_owner[d] = (state_q[d] == REQ) ? owner_q[d] : arb_owner[d];
      dev_act[d]   = !rst_i && ((state_q[d] == IDLE && arb_valid[d]) || state_q[d] == REQ);
      dev_hs[d]    = dev_act[d] && dev_gnt_i[d];
      state_d[d]   = state_q[d];
      unique case (state_q[d])
        IDLE:    if (arb_valid[d]) state_d[d] = dev_gnt_i[d] ? BUSY : REQ;
        REQ:     if (dev_gnt_i[d]) state_d[d] = BUSY;
        BUSY:    if (dev_rvalid_i[d]) state_d[d] = IDLE;
        default: state_d[d] = IDLE;
      endcase
    end
  end

  // Device-side request fields steered from each device's current owner.
  always_comb begin
    dev_req_o   = dev_act;
    dev_we_o    = '0;
    dev_be_o    = '0;
    dev_addr_o  = '0;
    dev_wdata_o = '0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (dev_act[d]) begin
        dev_we_o[d]             = host_we_i[cur_owner[d]];
        dev_be_o[d*BW +: BW]    = host_be_i[32'(cur_owner[d])*BW +: BW];
        dev_addr_o[d*AW +: AW]  = host_addr_i[32'(cur_owner[d])*AW +: AW];
        dev_wdata_o[d*DW +: DW] = host_wdata_i[32'(cur_owner[d])*DW +: DW];
      end
    end
  end

  // Host-side grant pass-through and response routing (device or decode error).
  always_comb begin
    host_gnt_o    = derr_gnt;
    host_rvalid_o = rst_i ? '0 : derr_q;
    host_err_o    = rst_i ? '0 : derr_q;
    host_rdata_o  = '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      for (int unsigned d = 0; d < NrDevices; d++) begin
        if (dev_hs[d] && cur_owner[d] == HW'(h)) host_gnt_o[h] = 1'b1;
        if (!rst_i && state_q[d] == BUSY && dev_rvalid_i[d] && owner_q[d] == HW'(h)) begin
          host_rvalid_o[h] = 1'b1;
          host_err_o[h]    = dev_err_i[d];
          host_rdata_o[h*DW +: DW] = dev_err_i[d] ? '0 : dev_rdata_i[d*DW +: DW];
        end
      end
    end
  end

  // State, ownership, fairness pointers, pending flags and stray-response flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q   <= '0;
      derr_q      <= '0;
      proto_err_q <= 1'b0;
      for (int unsigned d = 0; d < NrDevices; d++) begin
        state_q[d] <= IDLE;
        owner_q[d] <= '0;
        rr_q[d]    <= '0;
      end
    end else begin
      pending_q <= (pending_q & ~host_rvalid_o) | host_gnt_o;
      derr_q    <= derr_gnt;
      for (int unsigned d = 0; d < NrDevices; d++) begin
        state_q[d] <= state_d[d];
        if (state_q[d] == IDLE && arb_valid[d]) owner_q[d] <= arb_owner[d];
        if (dev_hs[d]) rr_q[d] <= (cur_owner[d] == HW'(NrHosts - 1)) ? '0 : cur_owner[d] + 1'b1;
        if (dev_rvalid_i[d] && state_q[d] != BUSY) proto_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_xbar_mn.sv
// Self-checking bench for bus_xbar_mn: decode table, directed multi-cycle
// sequences, and randomized traffic against an end-to-end transaction model.
module tb_bus_xbar_mn;
  localparam int NH = 2;
  localparam int ND = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic [ND*AW-1:0] cfg_base, cfg_mask;
  logic [NH-1:0]    host_req, host_we, host_gnt, host_rvalid, host_err;
  logic [NH*BW-1:0] host_be;
  logic [NH*AW-1:0] host_addr;
  logic [NH*DW-1:0] host_wdata, host_rdata;
  logic [ND-1:0]    dev_req, dev_we, dev_gnt, dev_rvalid, dev_err;
  logic [ND*BW-1:0] dev_be;
  logic [ND*AW-1:0] dev_addr;
  logic [ND*DW-1:0] dev_wdata, dev_rdata;
  logic             protocol_err;

  bus_xbar_mn #(.NrHosts(NH), .NrDevices(ND), .AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_addr_base_i(cfg_base), .cfg_addr_mask_i(cfg_mask),
    .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
    .host_err_o(host_err),
    .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_addr_o(dev_addr),
    .dev_wdata_o(dev_wdata),
    .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata),
    .dev_err_i(dev_err), .protocol_err_o(protocol_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    host_req = '0; host_we = '0; host_be = '0; host_addr = '0; host_wdata = '0;
    dev_gnt = '0; dev_rvalid = '0; dev_rdata = '0; dev_err = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_host(input int h, input logic req, input logic we,
                          input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    host_req[h] = req;
    host_we[h]  = we;
    host_addr[h*AW +: AW]  = a;
    host_wdata[h*DW +: DW] = wd;
    host_be[h*BW +: BW]    = be;
  endtask

  function automatic logic [31:0] hrdata(input int h);
    return host_rdata[h*DW +: DW];
  endfunction

  function automatic logic [31:0] daddr(input int d);
    return dev_addr[d*AW +: AW];
  endfunction

  // Device map as plain address ranges; dev3 window overlaps dev0 and takes priority.
  function automatic int ref_dev(input logic [31:0] a);
    if (a >= 32'h0010_8000 && a < 32'h0010_9000) return 3;
    if (a >= 32'h0003_0000 && a < 32'h0004_0000) return 2;
    if (a >= 32'h0002_0000 && a < 32'h0003_0000) return 1;
    if (a >= 32'h0010_0000 && a < 32'h0020_0000) return 0;
    return -1;
  endfunction

  function automatic logic [31:0] resp_data(input logic [31:0] a, input int d);
    return (a ^ 32'h5A5A_0000) + 32'(d);
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  exp_req;
    logic        exp_gnt;
  } vec_t;

  vec_t vecs[10];

  typedef enum int {H_IDLE, H_REQ, H_WAIT_DEV, H_WAIT_ERR} hst_e;
  hst_e        hs    [NH];
  logic [31:0] h_addr[NH];
  logic [31:0] h_wd  [NH];
  logic        h_we  [NH];
  logic [3:0]  h_be  [NH];
  int          h_dev [NH];
  int          h_age [NH];
  bit          d_busy[ND];
  bit          d_resp[ND];
  int          d_cnt [ND];
  logic [31:0] d_rdata[ND];
  logic        d_err [ND];

  initial begin
    cfg_base = {32'h0010_8000, 32'h0003_0000, 32'h0002_0000, 32'h0010_0000};
    cfg_mask = {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFF0_0000};
    rst = 1'b1;
    clear_inputs();

    vecs[0] = '{32'h0010_0000, 4'b0001, 1'b0};
    vecs[1] = '{32'h0010_0FFC, 4'b0001, 1'b0};
    vecs[2] = '{32'h001F_FFFC, 4'b0001, 1'b0};
    vecs[3] = '{32'h0010_8004, 4'b1000, 1'b0};
    vecs[4] = '{32'h0002_0000, 4'b0010, 1'b0};
    vecs[5] = '{32'h0002_FFFC, 4'b0010, 1'b0};
    vecs[6] = '{32'h0003_1234, 4'b0100, 1'b0};
    vecs[7] = '{32'h0000_0000, 4'b0000, 1'b1};
    vecs[8] = '{32'h0020_0000, 4'b0000, 1'b1};
    vecs[9] = '{32'h0001_FFFC, 4'b0000, 1'b1};

    do_reset();
    step();
    #1;
    chk("reset_host_gnt", host_gnt, '0);
    chk("reset_host_rvalid", host_rvalid, '0);
    chk("reset_dev_req", dev_req, '0);
    chk("reset_protocol_err", protocol_err, 1'b0);

    // Decode table: request is withdrawn before the clock edge so no state is taken.
    for (int i = 0; i < 10; i++) begin
      int h;
      logic [NH-1:0] eg;
      h = i % NH;
      step();
      set_host(h, 1'b1, 1'b0, vecs[i].addr, 32'h0, 4'hF);
      #1;
      eg = vecs[i].exp_gnt ? NH'(1 << h) : '0;
      chk("vec_dev_req", dev_req, vecs[i].exp_req);
      chk("vec_host_gnt", host_gnt, eg);
      for (int d = 0; d < ND; d++)
        if (vecs[i].exp_req[d]) chk("vec_dev_addr", daddr(d), vecs[i].addr);
      host_req = '0;
    end

    // Single read with same-cycle grant and next-cycle response.
    do_reset();
    step();
    set_host(0, 1'b1, 1'b0, 32'h0010_0000, 32'h0, 4'hF);
    dev_gnt[0] = 1'b1;
    #1;
    chk("t1_gnt", host_gnt, 2'b01);
    chk("t1_dev_req", dev_req, 4'b0001);
    chk("t1_dev_addr", daddr(0), 32'h0010_0000);
    chk("t1_no_rvalid_yet", host_rvalid, '0);
    step();
    host_req = '0; dev_gnt = '0;
    dev_rvalid[0] = 1'b1; dev_rdata[0 +: DW] = 32'hDEAD_BEEF;
    #1;
    chk("t1_rvalid", host_rvalid, 2'b01);
    chk("t1_rdata", hrdata(0), 32'hDEAD_BEEF);
    chk("t1_err", host_err, '0);
    step();
    dev_rvalid = '0;
    #1;
    chk("t1_rvalid_done", host_rvalid, '0);

    // Round-robin rotation on a contended device.
    do_reset();
    step();
    set_host(0, 1'b1, 1'b0, 32'h0010_0000, 32'h0, 4'hF);
    set_host(1, 1'b1, 1'b0, 32'h0010_0004, 32'h0, 4'hF);
    dev_gnt[0] = 1'b1;
    #1; chk("rr_r1_gnt", host_gnt, 2'b01);
    step(); host_req[0] = 1'b0; dev_rvalid[0] = 1'b1;
    #1; chk("rr_r1_rvalid", host_rvalid, 2'b01); chk("rr_busy_no_req", dev_req, '0);
    step(); host_req[0] = 1'b1; dev_rvalid[0] = 1'b0;
    #1; chk("rr_r2_gnt", host_gnt, 2'b10); chk("rr_r2_addr", daddr(0), 32'h0010_0004);
    step(); host_req[1] = 1'b0; dev_rvalid[0] = 1'b1;
    #1; chk("rr_r2_rvalid", host_rvalid, 2'b10);
    step(); host_req[1] = 1'b1; dev_rvalid[0] = 1'b0;
    #1; chk("rr_r3_gnt", host_gnt, 2'b01);
    step(); host_req = '0; dev_rvalid[0] = 1'b1;
    #1; chk("rr_r3_rvalid", host_rvalid, 2'b01);
    step(); dev_rvalid = '0; dev_gnt = '0;

    // Decode error: immediate grant, error response next cycle, devices untouched.
    do_reset();
    step();
    dev_rdata = '1;
    set_host(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
    #1;
    chk("t3_gnt", host_gnt, 2'b10);
    chk("t3_dev_req0", dev_req, '0);
    step(); host_req = '0;
    #1;
    chk("t3_rvalid", host_rvalid, 2'b10);
    chk("t3_err", host_err, 2'b10);
    chk("t3_rdata", hrdata(1), 32'h0);
    chk("t3_dev_req1", dev_req, '0);
    step();
    #1;
    chk("t3_rvalid_done", host_rvalid, '0);
    chk("t3_dev_req2", dev_req, '0);

    // Owner stays locked while the device withholds grant.
    do_reset();
    step();
    set_host(1, 1'b1, 1'b0, 32'h0003_0010, 32'h0, 4'hF);
    #1; chk("t4_req_c0", dev_req, 4'b0100); chk("t4_addr_c0", daddr(2), 32'h0003_0010);
    step(); set_host(0, 1'b1, 1'b0, 32'h0003_0020, 32'h0, 4'hF);
    #1; chk("t4_addr_c1", daddr(2), 32'h0003_0010); chk("t4_gnt_c1", host_gnt, '0);
    step();
    #1; chk("t4_addr_c2", daddr(2), 32'h0003_0010); chk("t4_gnt_c2", host_gnt, '0);
    step(); dev_gnt[2] = 1'b1;
    #1; chk("t4_gnt_c3", host_gnt, 2'b10); chk("t4_addr_c3", daddr(2), 32'h0003_0010);
    step(); host_req[1] = 1'b0; dev_gnt[2] = 1'b0; dev_rvalid[2] = 1'b1;
    #1; chk("t4_rvalid_h1", host_rvalid, 2'b10); chk("t4_busy_no_req", dev_req, '0);
    step(); dev_rvalid[2] = 1'b0; dev_gnt[2] = 1'b1;
    #1; chk("t4_gnt_h0", host_gnt, 2'b01); chk("t4_addr_h0", daddr(2), 32'h0003_0020);
    step(); host_req = '0; dev_gnt = '0; dev_rvalid[2] = 1'b1;
    #1; chk("t4_rvalid_h0", host_rvalid, 2'b01);
    step(); dev_rvalid = '0;

    // Two hosts on two devices in parallel, independent responses.
    do_reset();
    step();
    set_host(0, 1'b1, 1'b0, 32'h0002_0000, 32'h0, 4'hF);
    set_host(1, 1'b1, 1'b0, 32'h0003_0000, 32'h0, 4'hF);
    dev_gnt = 4'b0110;
    #1; chk("t5_gnt", host_gnt, 2'b11); chk("t5_dev_req", dev_req, 4'b0110);
    step(); host_req = '0; dev_gnt = '0;
    dev_rvalid = 4'b0100; dev_rdata[2*DW +: DW] = 32'h2222_2222;
    #1; chk("t5_rvalid_h1", host_rvalid, 2'b10); chk("t5_rdata_h1", hrdata(1), 32'h2222_2222);
    chk("t5_err_h1", host_err, '0);
    step(); dev_rvalid = 4'b0010; dev_rdata[1*DW +: DW] = 32'h1111_1111; dev_err[1] = 1'b1;
    #1; chk("t5_rvalid_h0", host_rvalid, 2'b01); chk("t5_err_h0", host_err, 2'b01);
    chk("t5_rdata_err_zero", hrdata(0), 32'h0);
    step(); dev_rvalid = '0; dev_err = '0;

    // Randomized traffic against host/device transaction models.
    do_reset();
    for (int h = 0; h < NH; h++) begin hs[h] = H_IDLE; h_age[h] = 0; h_dev[h] = 0; end
    for (int d = 0; d < ND; d++) begin d_busy[d] = 0; d_cnt[d] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [NH-1:0] exp_rv;
      step();
      for (int h = 0; h < NH; h++) begin
        if (hs[h] == H_IDLE && $urandom_range(2) == 0) begin
          case ($urandom_range(5))
            0:       h_addr[h] = 32'h0010_0000 | ($urandom & 32'h000F_FFFC);
            1:       h_addr[h] = 32'h0010_8000 | ($urandom & 32'h0000_0FFC);
            2:       h_addr[h] = 32'h0002_0000 | ($urandom & 32'h0000_FFFC);
            3:       h_addr[h] = 32'h0003_0000 | ($urandom & 32'h0000_FFFC);
            4:       h_addr[h] = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
            default: h_addr[h] = $urandom & 32'h0000_FFFC;
          endcase
          h_we[h] = 1'($urandom_range(1));
          h_wd[h] = $urandom;
          h_be[h] = 4'($urandom_range(15));
          hs[h] = H_REQ;
          h_age[h] = 0;
        end
        set_host(h, hs[h] == H_REQ, h_we[h], h_addr[h], h_wd[h], h_be[h]);
      end
      for (int d = 0; d < ND; d++) begin
        dev_gnt[d] = !d_busy[d] && ($urandom_range(1) == 1);
        d_resp[d] = d_busy[d] && d_cnt[d] == 0;
        dev_rvalid[d] = d_resp[d];
        dev_rdata[d*DW +: DW] = d_resp[d] ? d_rdata[d] : $urandom;
        dev_err[d] = d_resp[d] ? d_err[d] : 1'($urandom_range(1));
        if (d_busy[d] && d_cnt[d] > 0) d_cnt[d]--;
        if (d_resp[d]) d_busy[d] = 0;
      end
      #4;
      exp_rv = '0;
      for (int h = 0; h < NH; h++) begin
        if (hs[h] == H_WAIT_ERR) exp_rv[h] = 1'b1;
        if (hs[h] == H_WAIT_DEV && d_resp[h_dev[h]]) exp_rv[h] = 1'b1;
      end
      chk("rand_rvalid", host_rvalid, exp_rv);
      for (int h = 0; h < NH; h++) begin
        if (exp_rv[h]) begin
          if (hs[h] == H_WAIT_ERR) begin
            chk("rand_decerr_err", host_err[h], 1'b1);
            chk("rand_decerr_rdata", hrdata(h), 32'h0);
          end else begin
            chk("rand_resp_err", host_err[h], h_addr[h][3]);
            chk("rand_resp_rdata", hrdata(h), h_addr[h][3] ? 32'h0 : resp_data(h_addr[h], h_dev[h]));
          end
          hs[h] = H_IDLE;
        end else if (hs[h] == H_WAIT_DEV) begin
          h_age[h]++;
          if (h_age[h] == 50) chk("rand_resp_timeout", host_rvalid[h], 1'b1);
        end
      end
      for (int h = 0; h < NH; h++) begin
        int d;
        d = ref_dev(h_addr[h]);
        if (hs[h] != H_REQ) chk("rand_spurious_gnt", host_gnt[h], 1'b0);
        else if (d < 0) begin
          chk("rand_decerr_gnt", host_gnt[h], 1'b1);
          hs[h] = H_WAIT_ERR;
        end else if (host_gnt[h]) begin
          chk("rand_gnt_hs", dev_req[d] & dev_gnt[d], 1'b1);
          chk("rand_gnt_addr", daddr(d), h_addr[h]);
          chk("rand_gnt_fields", {dev_we[d], dev_be[d*BW +: BW], dev_wdata[d*DW +: DW]},
              {h_we[h], h_be[h], h_wd[h]});
          hs[h] = H_WAIT_DEV; h_dev[h] = d; h_age[h] = 0;
        end else begin
          h_age[h]++;
          if (h_age[h] == 100) chk("rand_gnt_timeout", host_gnt[h], 1'b1);
        end
      end
      for (int d = 0; d < ND; d++) begin
        if (dev_req[d] && dev_gnt[d]) begin
          int cnt;
          cnt = 0;
          for (int h = 0; h < NH; h++)
            if (host_gnt[h] && hs[h] == H_WAIT_DEV && h_dev[h] == d) cnt++;
          chk("rand_hs_owner", cnt, 1);
          d_busy[d] = 1; d_cnt[d] = $urandom_range(2);
          d_rdata[d] = resp_data(daddr(d), d);
          d_err[d] = daddr(d)[3];
        end else if (dev_req[d]) begin
          bit found;
          found = 0;
          for (int h = 0; h < NH; h++)
            if (hs[h] == H_REQ && ref_dev(h_addr[h]) == d) found = 1;
          if (!found) chk("rand_stray_dev_req", dev_req[d], 1'b0);
        end
      end
    end
    chk("rand_protocol_err", protocol_err, 1'b0);

    // Reset mid-transaction, then a late response becomes a sticky protocol error.
    do_reset();
    step();
    set_host(0, 1'b1, 1'b0, 32'h0010_8040, 32'h0, 4'hF);
    dev_gnt[3] = 1'b1;
    #1; chk("t6_gnt", host_gnt, 2'b01); chk("t6_dev_req", dev_req, 4'b1000);
    step(); host_req = '0; dev_gnt = '0; rst = 1'b1;
    set_host(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
    #1; chk("t6_rst_gnt", host_gnt, '0); chk("t6_rst_dev_req", dev_req, '0);
    chk("t6_rst_rvalid", host_rvalid, '0);
    step(); rst = 1'b0; host_req = '0;
    dev_rvalid[3] = 1'b1; dev_rdata[3*DW +: DW] = 32'h3333_3333;
    #1; chk("t6_stray_not_routed", host_rvalid, '0); chk("t6_perr_before", protocol_err, 1'b0);
    step(); dev_rvalid = '0;
    #1; chk("t6_perr_set", protocol_err, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      #1; chk("t6_perr_sticky", protocol_err, 1'b1);
    end
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    #1; chk("t6_perr_cleared", protocol_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
